// File: rtl/sound_bus_pkg.sv
// Shared types and helpers for the sound board CPU-to-slave bus fabric.
package sound_bus_pkg;

    typedef enum logic {IDLE, WAIT} bus_state_t;

    localparam int unsigned DEF_MAX_WAIT = 7;
    localparam int unsigned WAIT_FIELD_W = 4;

    // Region match on up-to-32-bit addresses; callers zero-extend narrower buses.
    function automatic logic region_hit(input logic [31:0] addr,
                                        input logic [31:0] base,
                                        input logic [31:0] mask);
        return (addr & mask) == base;
    endfunction

endpackage

// File: rtl/sound_bus_decode.sv
// Combinational address decoder: priority-resolved one-hot hit, index and any-hit flag.
module sound_bus_decode
    import sound_bus_pkg::*;
#(
    parameter int unsigned N_SLAVES = 4,
    parameter int unsigned ADDR_W   = 16,
    parameter int unsigned IDX_W    = 2,
    parameter logic [N_SLAVES*ADDR_W-1:0] BASE = '0,
    parameter logic [N_SLAVES*ADDR_W-1:0] MASK = '0
) (
    input  logic [ADDR_W-1:0]   addr,
    output logic [N_SLAVES-1:0] hit_vec,
    output logic [IDX_W-1:0]    hit_idx,
    output logic                any_hit
);

    // Scan from the top so the lowest-index overlapping region wins.
    always_comb begin
        hit_vec = '0;
        hit_idx = '0;
        any_hit = 1'b0;
        for (int i = int'(N_SLAVES) - 1; i >= 0; i--) begin
            if (region_hit(32'(addr),
                           32'(BASE[i*ADDR_W +: ADDR_W]),
                           32'(MASK[i*ADDR_W +: ADDR_W]))) begin
                hit_vec = N_SLAVES'(1) << i;
                hit_idx = IDX_W'(i);
                any_hit = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sound_bus_fabric.sv
// 6502 sound-bus fabric: address decode, per-region wait states, registered read
// return with open-bus hold on unmapped reads.
module sound_bus_fabric
    import sound_bus_pkg::*;
#(
    parameter int unsigned N_SLAVES = 4,
    parameter int unsigned ADDR_W   = 16,
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned MAX_WAIT = DEF_MAX_WAIT,
    parameter logic [N_SLAVES*ADDR_W-1:0]       BASE = {16'h8000, 16'h1800, 16'h0000, 16'h0000},
    parameter logic [N_SLAVES*ADDR_W-1:0]       MASK = {16'hC000, 16'hFFF0, 16'hF000, 16'hF800},
    parameter logic [N_SLAVES*WAIT_FIELD_W-1:0] WAIT = {4'd1, 4'd2, 4'd3, 4'd0}
) (
    input  logic                       clock_15,
    input  logic                       rst_l,
    input  logic                       cpu_req,
    input  logic                       cpu_we,
    input  logic [ADDR_W-1:0]          cpu_addr,
    input  logic [DATA_W-1:0]          cpu_dout,
    output logic [DATA_W-1:0]          cpu_din,
    output logic                       cpu_rdy,
    output logic [N_SLAVES-1:0]        slv_sel,
    output logic                       slv_we,
    output logic [ADDR_W-1:0]          slv_addr,
    output logic [DATA_W-1:0]          slv_wdata,
    input  logic [N_SLAVES*DATA_W-1:0] slv_rdata,
    output logic                       decode_err
);

    localparam int unsigned CNT_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
    localparam int unsigned IDX_W = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;

    // Reject wait-state tables the counter cannot represent.
    for (genvar g = 0; g < int'(N_SLAVES); g++) begin : g_wait_chk
        if (32'(WAIT[g*WAIT_FIELD_W +: WAIT_FIELD_W]) > MAX_WAIT) begin : g_bad
            $error("sound_bus_fabric: WAIT of region %0d exceeds MAX_WAIT", g);
        end
    end

    bus_state_t           state;
    logic [CNT_W-1:0]     cnt;
    logic [ADDR_W-1:0]    lat_addr;
    logic [DATA_W-1:0]    lat_wdata;
    logic                 lat_we;
    logic [IDX_W-1:0]     lat_idx;

    logic [N_SLAVES-1:0]  hit_vec;
    logic [IDX_W-1:0]     hit_idx;
    logic                 any_hit;
    logic [CNT_W-1:0]     wait_live;
    logic [CNT_W-1:0]     wait_lat;
    logic [DATA_W-1:0]    rd_live;
    logic [DATA_W-1:0]    rd_lat;
    logic                 done;

    sound_bus_decode #(
        .N_SLAVES (N_SLAVES),
        .ADDR_W   (ADDR_W),
        .IDX_W    (IDX_W),
        .BASE     (BASE),
        .MASK     (MASK)
    ) u_decode (
        .addr     (cpu_addr),
        .hit_vec  (hit_vec),
        .hit_idx  (hit_idx),
        .any_hit  (any_hit)
    );

    assign wait_live = CNT_W'(WAIT[int'(hit_idx)*WAIT_FIELD_W +: WAIT_FIELD_W]);
    assign wait_lat  = CNT_W'(WAIT[int'(lat_idx)*WAIT_FIELD_W +: WAIT_FIELD_W]);
    assign rd_live   = slv_rdata[int'(hit_idx)*DATA_W +: DATA_W];
    assign rd_lat    = slv_rdata[int'(lat_idx)*DATA_W +: DATA_W];
    assign done      = (cnt == wait_lat);

    // Access sequencer: latches multi-cycle accesses and captures read data on completion.
    always_ff @(posedge clock_15 or negedge rst_l) begin
        if (!rst_l) begin
            state     <= IDLE;
            cnt       <= '0;
            cpu_din   <= '0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_we    <= 1'b0;
            lat_idx   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cpu_req && any_hit) begin
                        if (wait_live == '0) begin
                            if (!cpu_we) cpu_din <= rd_live;
                        end else begin
                            lat_addr  <= cpu_addr;
                            lat_wdata <= cpu_dout;
                            lat_we    <= cpu_we;
                            lat_idx   <= hit_idx;
                            cnt       <= CNT_W'(1);
                            state     <= sound_bus_pkg::WAIT;
                        end
                    end
                end
                default: begin
                    if (!cpu_req) begin
                        cnt   <= '0;
                        state <= IDLE;
                    end else if (done) begin
                        if (!lat_we) cpu_din <= rd_lat;
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
            endcase
        end
    end

    // Slave-side drive: live CPU inputs when idle, latched access while waiting.
    always_comb begin
        slv_sel    = '0;
        slv_we     = 1'b0;
        slv_addr   = cpu_addr;
        slv_wdata  = cpu_dout;
        cpu_rdy    = 1'b1;
        decode_err = 1'b0;
        if (rst_l) begin
            case (state)
                IDLE: begin
                    if (cpu_req) begin
                        if (any_hit) begin
                            slv_sel = hit_vec;
                            if (wait_live == '0) slv_we  = cpu_we;
                            else                 cpu_rdy = 1'b0;
                        end else begin
                            decode_err = 1'b1;
                        end
                    end
                end
                default: begin
                    slv_addr  = lat_addr;
                    slv_wdata = lat_wdata;
                    if (cpu_req) begin
                        slv_sel = N_SLAVES'(1) << lat_idx;
                        cpu_rdy = done;
                        slv_we  = lat_we && done;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sound_bus_fabric.sv
// Directed bench for sound_bus_fabric: decode, wait states, open bus, reset abort, back-to-back.
module tb_sound_bus_fabric;

    logic        clock_15;
    logic        rst_l;
    logic        cpu_req;
    logic        cpu_we;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_dout;
    logic [7:0]  cpu_din;
    logic        cpu_rdy;
    logic [3:0]  slv_sel;
    logic        slv_we;
    logic [15:0] slv_addr;
    logic [7:0]  slv_wdata;
    logic [31:0] slv_rdata;
    logic        decode_err;

    int total = 0;
    int bad   = 0;
    int strobes = 0;

    sound_bus_fabric #(
        .N_SLAVES (4),
        .ADDR_W   (16),
        .DATA_W   (8),
        .MAX_WAIT (7),
        .BASE     ({16'h8000, 16'h1800, 16'h0000, 16'h0000}),
        .MASK     ({16'hC000, 16'hFFF0, 16'hF000, 16'hF800}),
        .WAIT     ({4'd1, 4'd2, 4'd3, 4'd0})
    ) dut (
        .clock_15   (clock_15),
        .rst_l      (rst_l),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_dout   (cpu_dout),
        .cpu_din    (cpu_din),
        .cpu_rdy    (cpu_rdy),
        .slv_sel    (slv_sel),
        .slv_we     (slv_we),
        .slv_addr   (slv_addr),
        .slv_wdata  (slv_wdata),
        .slv_rdata  (slv_rdata),
        .decode_err (decode_err)
    );

    initial clock_15 = 1'b0;
    always #5 clock_15 = ~clock_15;

    always @(posedge clock_15) if (slv_we === 1'b1) strobes++;

    task automatic cycle();
        @(posedge clock_15);
        #1;
    endtask

    task automatic set_bus(input logic req, input logic we, input logic [15:0] a, input logic [7:0] d);
        cpu_req  = req;
        cpu_we   = we;
        cpu_addr = a;
        cpu_dout = d;
        #2;
    endtask

    task automatic test_reset();
        rst_l = 1'b0;
        set_bus(1'b0, 1'b0, 16'h0000, 8'h00);
        slv_rdata = 32'h0;
        #12;
        total++; if (cpu_din !== 8'h00) begin bad++; $display("FAIL rst_din got=%h exp=00", cpu_din); end
        total++; if (cpu_rdy !== 1'b1) begin bad++; $display("FAIL rst_rdy got=%b exp=1", cpu_rdy); end
        total++; if (slv_sel !== 4'b0000) begin bad++; $display("FAIL rst_sel got=%b exp=0000", slv_sel); end
        total++; if (slv_we !== 1'b0) begin bad++; $display("FAIL rst_we got=%b exp=0", slv_we); end
        total++; if (decode_err !== 1'b0) begin bad++; $display("FAIL rst_derr got=%b exp=0", decode_err); end
        @(negedge clock_15);
        rst_l = 1'b1;
    endtask

    task automatic test_zero_wait_read();
        slv_rdata = {8'h44, 8'h33, 8'h22, 8'hA5};
        cycle(); set_bus(1'b1, 1'b0, 16'h0012, 8'h00);
        total++; if (slv_sel !== 4'b0001) begin bad++; $display("FAIL zw_sel got=%b exp=0001", slv_sel); end
        total++; if (cpu_rdy !== 1'b1) begin bad++; $display("FAIL zw_rdy got=%b exp=1", cpu_rdy); end
        total++; if (slv_we !== 1'b0) begin bad++; $display("FAIL zw_we got=%b exp=0", slv_we); end
        total++; if (slv_addr !== 16'h0012) begin bad++; $display("FAIL zw_addr got=%h exp=0012", slv_addr); end
        total++; if (cpu_din !== 8'h00) begin bad++; $display("FAIL zw_din_early got=%h exp=00", cpu_din); end
        cycle(); set_bus(1'b0, 1'b0, 16'h0000, 8'h00);
        total++; if (cpu_din !== 8'hA5) begin bad++; $display("FAIL zw_din got=%h exp=A5", cpu_din); end
        total++; if (slv_sel !== 4'b0000) begin bad++; $display("FAIL zw_idle_sel got=%b exp=0000", slv_sel); end
    endtask

    task automatic test_wait_write();
        cycle(); set_bus(1'b1, 1'b1, 16'h1803, 8'h5C);
        for (int k = 0; k < 3; k++) begin
            if (k > 0) begin
                cycle();
                if (k == 1) cpu_addr = 16'h0012;
                #2;
            end
            total++; if (slv_sel !== 4'b0100) begin bad++; $display("FAIL ww_sel%0d got=%b exp=0100", k, slv_sel); end
            total++; if (cpu_rdy !== (k == 2)) begin bad++; $display("FAIL ww_rdy%0d got=%b exp=%b", k, cpu_rdy, k == 2); end
            total++; if (slv_we !== (k == 2)) begin bad++; $display("FAIL ww_we%0d got=%b exp=%b", k, slv_we, k == 2); end
            total++; if (slv_addr !== 16'h1803) begin bad++; $display("FAIL ww_addr%0d got=%h exp=1803", k, slv_addr); end
            total++; if (slv_wdata !== 8'h5C) begin bad++; $display("FAIL ww_data%0d got=%h exp=5C", k, slv_wdata); end
        end
        cycle(); set_bus(1'b0, 1'b0, 16'h0000, 8'h00);
        total++; if (slv_we !== 1'b0) begin bad++; $display("FAIL ww_after_we got=%b exp=0", slv_we); end
        total++; if (cpu_rdy !== 1'b1) begin bad++; $display("FAIL ww_after_rdy got=%b exp=1", cpu_rdy); end
    endtask

    task automatic test_unmapped();
        slv_rdata = {8'h44, 8'h33, 8'h22, 8'h3C};
        cycle(); set_bus(1'b1, 1'b0, 16'h0010, 8'h00);
        cycle(); set_bus(1'b1, 1'b0, 16'hFFFF, 8'h00);
        total++; if (cpu_din !== 8'h3C) begin bad++; $display("FAIL um_prev_din got=%h exp=3C", cpu_din); end
        total++; if (decode_err !== 1'b1) begin bad++; $display("FAIL um_derr got=%b exp=1", decode_err); end
        total++; if (slv_sel !== 4'b0000) begin bad++; $display("FAIL um_sel got=%b exp=0000", slv_sel); end
        total++; if (cpu_rdy !== 1'b1) begin bad++; $display("FAIL um_rdy got=%b exp=1", cpu_rdy); end
        cycle(); set_bus(1'b1, 1'b1, 16'hFFFF, 8'hEE);
        total++; if (decode_err !== 1'b1) begin bad++; $display("FAIL um_wr_derr got=%b exp=1", decode_err); end
        total++; if (slv_we !== 1'b0) begin bad++; $display("FAIL um_wr_we got=%b exp=0", slv_we); end
        cycle(); set_bus(1'b0, 1'b0, 16'h0000, 8'h00);
        total++; if (decode_err !== 1'b0) begin bad++; $display("FAIL um_derr_end got=%b exp=0", decode_err); end
        total++; if (cpu_din !== 8'h3C) begin bad++; $display("FAIL um_openbus got=%h exp=3C", cpu_din); end
    endtask

    task automatic test_overlap();
        slv_rdata = {8'h44, 8'h33, 8'h22, 8'h11};
        cycle(); set_bus(1'b1, 1'b0, 16'h0100, 8'h00);
        total++; if (slv_sel !== 4'b0001) begin bad++; $display("FAIL ov_sel got=%b exp=0001", slv_sel); end
        total++; if (cpu_rdy !== 1'b1) begin bad++; $display("FAIL ov_rdy got=%b exp=1", cpu_rdy); end
        cycle(); set_bus(1'b1, 1'b0, 16'h0900, 8'h00);
        total++; if (cpu_din !== 8'h11) begin bad++; $display("FAIL ov_din got=%h exp=11", cpu_din); end
        total++; if (slv_sel !== 4'b0010) begin bad++; $display("FAIL ov_r1_sel got=%b exp=0010", slv_sel); end
        total++; if (cpu_rdy !== 1'b0) begin bad++; $display("FAIL ov_r1_rdy got=%b exp=0", cpu_rdy); end
        cycle(); set_bus(1'b0, 1'b0, 16'h0900, 8'h00);
        total++; if (slv_sel !== 4'b0000) begin bad++; $display("FAIL ov_abort_sel got=%b exp=0000", slv_sel); end
        cycle();
        total++; if (cpu_din !== 8'h11) begin bad++; $display("FAIL ov_abort_din got=%h exp=11", cpu_din); end
    endtask

    task automatic test_reset_mid();
        cycle(); set_bus(1'b1, 1'b1, 16'h0900, 8'h77);
        cycle();
        cycle();
        rst_l = 1'b0;
        #1;
        total++; if (cpu_rdy !== 1'b1) begin bad++; $display("FAIL rm_rdy got=%b exp=1", cpu_rdy); end
        total++; if (slv_sel !== 4'b0000) begin bad++; $display("FAIL rm_sel got=%b exp=0000", slv_sel); end
        total++; if (slv_we !== 1'b0) begin bad++; $display("FAIL rm_we got=%b exp=0", slv_we); end
        total++; if (cpu_din !== 8'h00) begin bad++; $display("FAIL rm_din got=%h exp=00", cpu_din); end
        cycle();
        cycle();
        set_bus(1'b0, 1'b0, 16'h0000, 8'h00);
        @(negedge clock_15);
        rst_l = 1'b1;
    endtask

    task automatic test_back_to_back();
        slv_rdata = {8'hC3, 8'h33, 8'h22, 8'h11};
        cycle(); set_bus(1'b1, 1'b0, 16'h8000, 8'h00);
        total++; if (slv_sel !== 4'b1000) begin bad++; $display("FAIL bb_sel0 got=%b exp=1000", slv_sel); end
        total++; if (cpu_rdy !== 1'b0) begin bad++; $display("FAIL bb_rdy0 got=%b exp=0", cpu_rdy); end
        cycle(); #2;
        total++; if (slv_sel !== 4'b1000) begin bad++; $display("FAIL bb_sel1 got=%b exp=1000", slv_sel); end
        total++; if (cpu_rdy !== 1'b1) begin bad++; $display("FAIL bb_rdy1 got=%b exp=1", cpu_rdy); end
        cycle(); set_bus(1'b1, 1'b1, 16'h0020, 8'h9E);
        total++; if (cpu_din !== 8'hC3) begin bad++; $display("FAIL bb_din got=%h exp=C3", cpu_din); end
        total++; if (slv_sel !== 4'b0001) begin bad++; $display("FAIL bb_wr_sel got=%b exp=0001", slv_sel); end
        total++; if (slv_we !== 1'b1) begin bad++; $display("FAIL bb_wr_we got=%b exp=1", slv_we); end
        total++; if (slv_wdata !== 8'h9E) begin bad++; $display("FAIL bb_wr_data got=%h exp=9E", slv_wdata); end
        cycle(); set_bus(1'b1, 1'b1, 16'h1805, 8'hAA);
        total++; if (slv_sel !== 4'b0100) begin bad++; $display("FAIL bb_dr_sel got=%b exp=0100", slv_sel); end
        total++; if (slv_we !== 1'b0) begin bad++; $display("FAIL bb_dr_we0 got=%b exp=0", slv_we); end
        cycle(); set_bus(1'b0, 1'b1, 16'h1805, 8'hAA);
        total++; if (slv_we !== 1'b0) begin bad++; $display("FAIL bb_dr_we1 got=%b exp=0", slv_we); end
        total++; if (slv_sel !== 4'b0000) begin bad++; $display("FAIL bb_dr_sel1 got=%b exp=0000", slv_sel); end
        cycle(); #2;
        total++; if (slv_we !== 1'b0) begin bad++; $display("FAIL bb_dr_we2 got=%b exp=0", slv_we); end
        total++; if (cpu_rdy !== 1'b1) begin bad++; $display("FAIL bb_dr_rdy got=%b exp=1", cpu_rdy); end
        total++; if (cpu_din !== 8'hC3) begin bad++; $display("FAIL bb_dr_din got=%h exp=C3", cpu_din); end
        cycle();
        total++; if (strobes !== 2) begin bad++; $display("FAIL strobe_count got=%0d exp=2", strobes); end
    endtask

    initial begin
        test_reset();
        test_zero_wait_read();
        test_wait_write();
        test_unmapped();
        test_overlap();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
